// File: rtl/sim_frame_trigger.sv
// ---------------------------------------------------------------------------
// sim_frame_trigger
//
// Purpose:
//   Opens a capture ("dump") window on a chosen video frame so that a
//   simulation can record only the frames of interest. Frames are counted on
//   falling edges of the active-low vertical sync. The window opens on the VS
//   edge seen while frame_cnt equals START_FRAME. It then stays open for
//   DUMP_FRAMES further edges, or forever when DUMP_FRAMES is 0.
//
// Optional feature (macro DUMP_LOADWAIT_EN):
//   When the macro is defined, the block waits in WAIT_LOAD until a ROM
//   download has finished. The falling edge of the registered downloading
//   signal arms it. A new download (rising edge of downloading) restarts it
//   from WAIT_LOAD and clears frame_cnt. When the macro is not defined, the
//   downloading input is ignored and the block comes out of reset armed.
//
// Parameters:
//   START_FRAME  frame_cnt value, sampled at a VS edge, that opens the window
//   DUMP_FRAMES  number of VS edges the window stays open (0 = unlimited)
//
// Ports:
//   clk          single clock, all logic on the rising edge
//   rst          synchronous reset, active-high
//   vs           vertical sync, active-low pulse
//   downloading  ROM download in progress (used only with DUMP_LOADWAIT_EN)
//   frame_cnt    VS falling edges counted since arming
//   dump_start   one-cycle pulse when the window opens
//   dump_stop    one-cycle pulse when the window closes
//   dump_active  high while the window is open
// ---------------------------------------------------------------------------
module sim_frame_trigger #(
    parameter logic [31:0] START_FRAME = 32'd0,
    parameter logic [31:0] DUMP_FRAMES = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vs,
    input  logic        downloading,
    output logic [31:0] frame_cnt,
    output logic        dump_start,
    output logic        dump_stop,
    output logic        dump_active
);

    typedef enum logic [1:0] {
        WAIT_LOAD = 2'd0,
        ARMED     = 2'd1,
        ACTIVE    = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_vs_l;
    logic [31:0] r_frame_cnt;
    logic [31:0] w_frame_cnt_nxt;
    logic [31:0] r_win_cnt;
    logic [31:0] w_win_cnt_nxt;
    logic        r_dump_start;
    logic        w_dump_start_nxt;
    logic        r_dump_stop;
    logic        w_dump_stop_nxt;
    logic        r_dump_active;
    logic        w_dump_active_nxt;

    logic        w_vs_edge;
    logic        w_dl_rise;
    logic        w_dl_fall;

    // A frame boundary is the cycle where VS was high last cycle and is low now.
    assign w_vs_edge = r_vs_l & ~vs;

`ifdef DUMP_LOADWAIT_EN
    localparam state_t RESET_STATE = WAIT_LOAD;

    logic r_dl_l;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dl_l <= 1'b0;
        end else begin
            r_dl_l <= downloading;
        end
    end

    assign w_dl_rise = downloading & ~r_dl_l;
    assign w_dl_fall = r_dl_l & ~downloading;
`else
    localparam state_t RESET_STATE = ARMED;

    // The download handshake does not exist in this build, so the input is
    // deliberately left unused.
    logic w_unused_downloading;
    assign w_unused_downloading = downloading;

    assign w_dl_rise = 1'b0;
    assign w_dl_fall = 1'b0;
`endif

    // Next-state and next-output logic.
    always_comb begin
        // NOTE: every signal gets a default before any branch so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_state_nxt       = r_state;
        w_frame_cnt_nxt   = r_frame_cnt;
        w_win_cnt_nxt     = r_win_cnt;
        w_dump_start_nxt  = 1'b0;
        w_dump_stop_nxt   = 1'b0;
        w_dump_active_nxt = r_dump_active;

        if (w_dl_rise && (r_state != WAIT_LOAD)) begin
            // A new download restarts the block. It wins over a VS edge in the
            // same cycle, and that edge is dropped. Only an open window
            // reports its closure.
            w_state_nxt       = WAIT_LOAD;
            w_frame_cnt_nxt   = 32'd0;
            w_win_cnt_nxt     = 32'd0;
            w_dump_stop_nxt   = (r_state == ACTIVE);
            w_dump_active_nxt = 1'b0;
        end else begin
            unique case (r_state)
                WAIT_LOAD: begin
                    // frame_cnt is already 0 here, and VS edges are ignored.
                    if (w_dl_fall) begin
                        w_state_nxt = ARMED;
                    end
                end
                ARMED: begin
                    if (w_vs_edge) begin
                        w_frame_cnt_nxt = r_frame_cnt + 32'd1;
                        // The compare uses the count before the increment.
                        if (r_frame_cnt == START_FRAME) begin
                            w_state_nxt       = ACTIVE;
                            w_win_cnt_nxt     = 32'd0;
                            w_dump_start_nxt  = 1'b1;
                            w_dump_active_nxt = 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (w_vs_edge) begin
                        w_frame_cnt_nxt = r_frame_cnt + 32'd1;
                        w_win_cnt_nxt   = r_win_cnt + 32'd1;
                        // The window closes on the edge that brings the
                        // in-window count up to DUMP_FRAMES.
                        if ((DUMP_FRAMES != 32'd0) &&
                            ((r_win_cnt + 32'd1) == DUMP_FRAMES)) begin
                            w_state_nxt       = DONE;
                            w_dump_stop_nxt   = 1'b1;
                            w_dump_active_nxt = 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (w_vs_edge) begin
                        w_frame_cnt_nxt = r_frame_cnt + 32'd1;
                    end
                end
                default: begin
                    w_state_nxt = RESET_STATE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the values from before the clock edge.
        if (rst) begin
            // NOTE: every register, including the window counter, is reset.
            // A reset mid-window clears dump_active and produces no dump_stop.
            r_state       <= RESET_STATE;
            r_vs_l        <= 1'b1;
            r_frame_cnt   <= 32'd0;
            r_win_cnt     <= 32'd0;
            r_dump_start  <= 1'b0;
            r_dump_stop   <= 1'b0;
            r_dump_active <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_vs_l        <= vs;
            r_frame_cnt   <= w_frame_cnt_nxt;
            r_win_cnt     <= w_win_cnt_nxt;
            r_dump_start  <= w_dump_start_nxt;
            r_dump_stop   <= w_dump_stop_nxt;
            r_dump_active <= w_dump_active_nxt;
        end
    end

    assign frame_cnt   = r_frame_cnt;
    assign dump_start  = r_dump_start;
    assign dump_stop   = r_dump_stop;
    assign dump_active = r_dump_active;

endmodule

// File: tb/tb_sim_frame_trigger.sv
// ---------------------------------------------------------------------------
// tb_sim_frame_trigger
//
// Drives three instances of sim_frame_trigger from shared inputs. The
// instances use different parameter sets:
//   u0: START_FRAME=3, DUMP_FRAMES=2
//   u1: START_FRAME=0, DUMP_FRAMES=0 (unlimited window)
//   u2: START_FRAME=1, DUMP_FRAMES=1
// Expected outputs come from an event-level model of frame counting and of
// the capture window. The model follows the DUT's compile-time macro
// DUMP_LOADWAIT_EN.
// ---------------------------------------------------------------------------
module tb_sim_frame_trigger;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              vs = 1'b1;
    logic              downloading = 1'b0;
    logic [2:0][31:0]  fc;
    logic [2:0]        st;
    logic [2:0]        sp;
    logic [2:0]        ac;

    always #5 clk = ~clk;

    sim_frame_trigger #(.START_FRAME(32'd3), .DUMP_FRAMES(32'd2)) u0 (
        .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
        .frame_cnt(fc[0]), .dump_start(st[0]), .dump_stop(sp[0]), .dump_active(ac[0]));
    sim_frame_trigger #(.START_FRAME(32'd0), .DUMP_FRAMES(32'd0)) u1 (
        .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
        .frame_cnt(fc[1]), .dump_start(st[1]), .dump_stop(sp[1]), .dump_active(ac[1]));
    sim_frame_trigger #(.START_FRAME(32'd1), .DUMP_FRAMES(32'd1)) u2 (
        .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
        .frame_cnt(fc[2]), .dump_start(st[2]), .dump_stop(sp[2]), .dump_active(ac[2]));

`ifdef DUMP_LOADWAIT_EN
    localparam bit LOADWAIT = 1'b1;
`else
    localparam bit LOADWAIT = 1'b0;
`endif

    int n_chk = 0;
    int n_err = 0;

    // Model state for each instance, kept in terms of frames and window events.
    bit [31:0]   m_cnt     [3];
    bit          m_opened  [3];
    bit          m_closed  [3];
    bit          m_loading [3];
    bit          m_start   [3];
    bit          m_stop    [3];
    bit          m_active  [3];
    int unsigned m_win     [3];
    bit          m_vs_prev;
    bit          m_dl_prev;

    function automatic bit [31:0] start_frame(int c);
        case (c)
            0:       return 32'd3;
            1:       return 32'd0;
            default: return 32'd1;
        endcase
    endfunction

    function automatic int unsigned dump_frames(int c);
        case (c)
            0:       return 2;
            1:       return 0;
            default: return 1;
        endcase
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < 3; c++) begin
            m_cnt[c]     = '0;
            m_opened[c]  = 1'b0;
            m_closed[c]  = 1'b0;
            m_loading[c] = LOADWAIT;
            m_start[c]   = 1'b0;
            m_stop[c]    = 1'b0;
            m_active[c]  = 1'b0;
            m_win[c]     = 0;
        end
        m_vs_prev = 1'b1;
        m_dl_prev = 1'b0;
    endfunction

    // Advance the model by one clock using the inputs that were applied
    // during that clock.
    function automatic void model_step(bit v, bit d);
        bit frame_edge;
        bit load_begin;
        bit load_end;
        frame_edge = m_vs_prev && !v;
        load_begin = LOADWAIT && d && !m_dl_prev;
        load_end   = LOADWAIT && m_dl_prev && !d;
        for (int c = 0; c < 3; c++) begin
            m_start[c] = 1'b0;
            m_stop[c]  = 1'b0;
            if (load_begin && !m_loading[c]) begin
                m_stop[c]    = m_opened[c] && !m_closed[c];
                m_active[c]  = 1'b0;
                m_cnt[c]     = '0;
                m_loading[c] = 1'b1;
                m_opened[c]  = 1'b0;
                m_closed[c]  = 1'b0;
                m_win[c]     = 0;
            end else if (m_loading[c]) begin
                if (load_end) m_loading[c] = 1'b0;
            end else if (frame_edge) begin
                if (!m_opened[c] && m_cnt[c] == start_frame(c)) begin
                    m_opened[c] = 1'b1;
                    m_start[c]  = 1'b1;
                    m_active[c] = 1'b1;
                end else if (m_opened[c] && !m_closed[c]) begin
                    m_win[c] = m_win[c] + 1;
                    if (dump_frames(c) != 0 && m_win[c] == dump_frames(c)) begin
                        m_closed[c] = 1'b1;
                        m_stop[c]   = 1'b1;
                        m_active[c] = 1'b0;
                    end
                end
                m_cnt[c] = m_cnt[c] + 32'd1;
            end
        end
        m_vs_prev = v;
        m_dl_prev = d;
    endfunction

    task automatic check(input string tag, input int c, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s u%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    // Apply one clock's inputs, advance the model at the rising edge, then
    // compare every instance shortly after that edge.
    task automatic cycle(input logic v, input logic d, input logic r);
        vs          = v;
        downloading = d;
        rst         = r;
        @(posedge clk);
        if (r) model_reset();
        else   model_step(v, d);
        #1;
        for (int c = 0; c < 3; c++) begin
            check("frame_cnt", c, fc[c], m_cnt[c]);
            check("dump_start", c, 32'(st[c]), 32'(m_start[c]));
            check("dump_stop", c, 32'(sp[c]), 32'(m_stop[c]));
            check("dump_active", c, 32'(ac[c]), 32'(m_active[c]));
            check("start_stop_excl", c, 32'(st[c] & sp[c]), 32'd0);
        end
    endtask

    task automatic pulse(input int lo, input int hi);
        repeat (lo) cycle(1'b0, 1'b0, 1'b0);
        repeat (hi) cycle(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();

        // Reset, then a download with no frames so that the block is armed.
        repeat (3) cycle(1'b1, 1'b0, 1'b1);
        repeat (2) cycle(1'b1, 1'b1, 1'b0);
        repeat (2) cycle(1'b1, 1'b0, 1'b0);

        // Directed window for u0: opens after edge 4, closes after edge 6.
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            check("dir_cnt", 0, fc[0], 32'(i));
            check("dir_start", 0, 32'(st[0]), 32'(i == 4));
            check("dir_stop", 0, 32'(sp[0]), 32'(i == 6));
            check("dir_active", 0, 32'(ac[0]), 32'(i == 4 || i == 5));
            repeat (3) cycle(1'b1, 1'b0, 1'b0);
        end

        // Reset, then five frames during a download, then the download ends.
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            cycle(1'b0, 1'b1, 1'b0);
            cycle(1'b1, 1'b1, 1'b0);
        end
        repeat (2) cycle(1'b1, 1'b0, 1'b0);

        // Random VS pulse widths over well over 100 frames.
        for (int p = 0; p < 110; p++) begin
            int lo;
            int hi;
            lo = int'($urandom_range(1, 3));
            hi = int'($urandom_range(1, 5));
            pulse(lo, hi);
        end

        // A new download starts on the same cycle as a VS edge while u1 is open.
        cycle(1'b0, 1'b1, 1'b0);
`ifdef DUMP_LOADWAIT_EN
        check("restart_stop", 1, 32'(sp[1]), 32'd1);
        check("restart_cnt", 1, fc[1], 32'd0);
`endif
        cycle(1'b1, 1'b1, 1'b0);
        repeat (2) cycle(1'b1, 1'b0, 1'b0);

        // Open the windows again, then reset in the middle of them.
        repeat (3) pulse(1, 3);
        cycle(1'b1, 1'b0, 1'b1);
        check("midrst_active", 1, 32'(ac[1]), 32'd0);
        check("midrst_stop", 1, 32'(sp[1]), 32'd0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        repeat (2) pulse(2, 2);

        // Load the frame counters with all ones, then wrap them on one edge.
        force u0.r_frame_cnt = 32'hFFFF_FFFF;
        force u1.r_frame_cnt = 32'hFFFF_FFFF;
        force u2.r_frame_cnt = 32'hFFFF_FFFF;
        #1;
        release u0.r_frame_cnt;
        release u1.r_frame_cnt;
        release u2.r_frame_cnt;
        for (int c = 0; c < 3; c++) m_cnt[c] = 32'hFFFF_FFFF;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) check("wrap", c, fc[c], 32'd0);
        repeat (3) pulse(1, 2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sim_frame_trigger.md
SIM_FRAME_TRIGGER -- requirements
Module: sim_frame_trigger

Interface
REQ-001 Parameter START_FRAME, default 0: value of frame_cnt, sampled at a VS falling edge, that opens the capture window.
REQ-002 Parameter DUMP_FRAMES, default 0: number of VS falling edges the window stays open; 0 means unlimited.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 vs  input  1  vertical sync from the video output, active-low pulse, asynchronous to frame logic but stable per clk.
REQ-006 downloading  input  1  ROM download in progress (high); used only when DUMP_LOADWAIT_EN is defined.
REQ-007 frame_cnt  output  32  count of VS falling edges since arming.
REQ-008 dump_start  output  1  one-cycle pulse when the capture window opens.
REQ-009 dump_stop  output  1  one-cycle pulse when the capture window closes.
REQ-010 dump_active  output  1  high while the capture window is open.

Function
REQ-011 Block SHALL register vs into vs_l each cycle; a VS edge SHALL be the cycle where vs_l=1 and vs=0.
REQ-012 States SHALL be WAIT_LOAD, ARMED, ACTIVE, DONE.
REQ-013 In ARMED, ACTIVE and DONE, each VS edge SHALL increment frame_cnt by 1 at the end of the edge cycle, wrapping from 32'hFFFFFFFF to 0.
REQ-014 In ARMED, a VS edge with pre-increment frame_cnt==START_FRAME SHALL move to ACTIVE, assert dump_start for exactly one cycle and set dump_active, both visible the cycle after the edge cycle.
REQ-015 In ACTIVE, an internal 32-bit window counter SHALL count VS edges, excluding the opening edge.
REQ-016 When DUMP_FRAMES!=0 and the window counter reaches DUMP_FRAMES, the block SHALL move to DONE, pulse dump_stop for one cycle and clear dump_active on the same cycle.
REQ-017 When DUMP_FRAMES==0, ACTIVE SHALL be left only by reset or by a download restart (REQ-020).
REQ-018 DONE SHALL be terminal until reset; frame_cnt keeps counting and no further dump_start is produced.
REQ-019 dump_start and dump_stop SHALL never be high in the same cycle; when DUMP_FRAMES==1, dump_stop comes on the cycle after the second VS edge.
REQ-020 With DUMP_LOADWAIT_EN, a rising downloading in any state other than WAIT_LOAD SHALL return to WAIT_LOAD and clear frame_cnt; if the block was ACTIVE, it SHALL pulse dump_stop and clear dump_active.
REQ-021 A download restart SHALL take priority over a VS edge in the same cycle; that VS edge is not counted.

Reset
REQ-022 On rst, frame_cnt=0, dump_start=0, dump_stop=0, dump_active=0, vs_l=1, window counter=0.
REQ-023 Reset state SHALL be WAIT_LOAD with DUMP_LOADWAIT_EN, ARMED without it.
REQ-024 Reset asserted mid-window SHALL clear dump_active without producing a dump_stop pulse.

Configuration
REQ-025 Macro DUMP_LOADWAIT_EN defined: in WAIT_LOAD, frame_cnt is held at 0 and VS edges are ignored; the falling edge of downloading (registered) moves to ARMED.
REQ-026 Macro DUMP_LOADWAIT_EN undefined: WAIT_LOAD is unreachable, downloading is ignored, and REQ-020 and REQ-021 do not apply.

Verification
REQ-027 START_FRAME=3, DUMP_FRAMES=2, no macro, 6 VS pulses -> dump_start the cycle after the 4th edge, with frame_cnt=4; dump_stop the cycle after the 6th edge, with frame_cnt=6; dump_active high across that window.
REQ-028 START_FRAME=0, DUMP_FRAMES=0 -> dump_start after the 1st edge; dump_active stays high for 100 frames; dump_stop never pulses.
REQ-029 With macro, downloading high for 5 VS pulses and then low, START_FRAME=1 -> frame_cnt stays 0 during download; dump_start after the 2nd post-download edge.
REQ-030 With macro, ACTIVE, downloading rises on the same cycle as a VS edge -> one dump_stop pulse, frame_cnt=0, state WAIT_LOAD, edge not counted.
REQ-031 frame_cnt forced to 32'hFFFFFFFF, then one VS edge -> frame_cnt=0, no spurious dump pulses; rst asserted mid-window -> all outputs 0 the next cycle.
